// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: oversamples sck/sdi/cs_n in the clk domain and
// assembles MSB-first 24-bit frames (command, databyte1, databyte2).
// Each complete frame is presented on held registers with a one-cycle spi_done.
// A partial frame cut short by cs_n release raises a one-cycle frame_err.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic [7:0] command,
  output logic [7:0] databyte1,
  output logic [7:0] databyte2,
  output logic       spi_done,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // The three pins use identical chains so that they stay time-aligned.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  state_t      state_q, state_d;
  logic [22:0] shift_q, shift_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] frame_q, frame_d;
  logic        spi_done_q, spi_done_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  logic sck_s, sdi_s, cs_n_s, rise;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;

  // Synchronizer chains shift the raw pin in at bit 0.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
    sck_prev_d  = sck_s;
  end

  // All state registers; synchronizers reset to the idle pin levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      cs_n_sync_q <= '1;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      spi_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      cs_n_sync_q <= cs_n_sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      spi_done_q  <= spi_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: chip select alone decides IDLE vs SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_n_s) state_d = SHIFT;
      SHIFT:   if (cs_n_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and strobes; a 24th rise wins over a simultaneous cs_n release.
  always_comb begin
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    spi_done_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = ~cs_n_s;
    case (state_q)
      IDLE: begin
        bitcnt_d = 5'd0;
      end
      SHIFT: begin
        if (rise && (bitcnt_q == 5'd23)) begin
          frame_d    = {shift_q, sdi_s};
          spi_done_d = 1'b1;
          bitcnt_d   = 5'd0;
        end else if (cs_n_s) begin
          frame_err_d = (bitcnt_q != 5'd0);
          bitcnt_d    = 5'd0;
        end else if (rise) begin
          shift_d  = {shift_q[21:0], sdi_s};
          bitcnt_d = bitcnt_q + 5'd1;
        end
      end
      default: bitcnt_d = 5'd0;
    endcase
  end

  assign command   = frame_q[23:16];
  assign databyte1 = frame_q[15:8];
  assign databyte2 = frame_q[7:0];
  assign spi_done  = spi_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: drives SPI mode-0 transactions at sck = clk/8 and
// checks every cycle against a frame-level model (bit stream -> 24-bit frames).
module tb_spi_frame_rx;

  logic       clk, reset, sck, sdi, cs_n;
  logic [7:0] command, databyte1, databyte2;
  logic       spi_done, frame_err, busy;

  int errors = 0;
  int checks = 0;

  // Model state: bits sent in the current cs_n assertion, frames still owed by
  // the DUT, the frame the outputs must hold, and expected/seen error pulses.
  logic [23:0] m_acc;
  int          m_cnt;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [23:0] held;
  int          exp_err, obs_err;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .command(command), .databyte1(databyte1), .databyte2(databyte2),
    .spi_done(spi_done), .frame_err(frame_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    checks++;
    if (spi_done && frame_err) begin
      errors++;
      $display("FAIL done_err_overlap: spi_done=1 frame_err=1 expected not both");
    end
    if (frame_err) obs_err++;
    if (spi_done) begin
      obs_q.push_back({command, databyte1, databyte2});
      $display("frame %02h %02h %02h at %0t", command, databyte1, databyte2, $time);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got frame %h expected no spi_done", {command, databyte1, databyte2});
      end else begin
        held = exp_q.pop_front();
      end
    end
    if ({command, databyte1, databyte2} !== held) begin
      errors++;
      $display("FAIL outputs: got %h expected %h", {command, databyte1, databyte2}, held);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_bit(input logic b);
    m_acc = {m_acc[22:0], b};
    m_cnt++;
    if (m_cnt == 24) begin
      exp_q.push_back(m_acc);
      m_cnt = 0;
    end
  endtask

  task automatic model_release();
    if (m_cnt != 0) exp_err++;
    m_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    sck = 1'b0;
    wait_clks(4);
    sck = 1'b1;
    model_bit(b);
    wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic cs_start();
    sck  = 1'b0;
    cs_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_stop();
    sck = 1'b0;
    wait_clks(4);
    cs_n = 1'b1;
    model_release();
    wait_clks(8);
  endtask

  task automatic end_test(input string name);
    wait_clks(6);
    chk({name, "_pending_frames"}, exp_q.size(), 0);
    chk({name, "_err_pulses"}, obs_err, exp_err);
  endtask

  initial begin
    logic [23:0] f6;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    m_acc = '0; m_cnt = 0; held = '0; exp_err = 0; obs_err = 0;
    wait_clks(3);
    chk("reset_outputs", {command, databyte1, databyte2}, 24'h000000);
    chk("reset_strobes", {spi_done, frame_err, busy}, 3'b000);
    reset = 1'b0;
    wait_clks(3);

    // 1: single frame A5 12 34
    cs_start();
    chk("busy_asserted", busy, 1'b1);
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    cs_stop();
    end_test("t1");
    chk("t1_frame", {command, databyte1, databyte2}, 24'hA51234);
    chk("busy_released", busy, 1'b0);

    // 2: burst of two frames in one assertion
    cs_start();
    send_byte(8'h81); send_byte(8'h03); send_byte(8'h1F);
    send_byte(8'h82); send_byte(8'h1F); send_byte(8'h00);
    cs_stop();
    end_test("t2");
    chk("t2_first", obs_q[1], 24'h81031F);
    chk("t2_second", obs_q[2], 24'h821F00);

    // 3: aborted 10-bit frame
    cs_start();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    cs_stop();
    end_test("t3");
    chk("t3_err_count", obs_err, 1);
    chk("t3_frame_kept", {command, databyte1, databyte2}, 24'h821F00);
    chk("t3_no_done", obs_q.size(), 3);

    // 4: pin activity with cs_n high is ignored
    for (int i = 0; i < 30; i++) begin
      sck = ~sck;
      sdi = i[1];
      wait_clks(2);
      chk("t4_busy", busy, 1'b0);
    end
    sck = 1'b0;
    end_test("t4");
    chk("t4_no_done", obs_q.size(), 3);

    // 5: reset in the middle of a frame, then a clean frame
    cs_start();
    send_byte(8'hDE); send_byte(8'hAD);
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0;
    held = '0; m_cnt = 0;
    wait_clks(2);
    chk("t5_reset_outputs", {command, databyte1, databyte2}, 24'h000000);
    reset = 1'b0;
    wait_clks(4);
    cs_start();
    send_byte(8'hC0); send_byte(8'h00); send_byte(8'h05);
    cs_stop();
    end_test("t5");
    chk("t5_frame", obs_q[3], 24'hC00005);
    chk("t5_err_none", obs_err, 1);

    // 6: cs_n released together with the 24th sck rise
    f6 = 24'h7F0102;
    cs_start();
    for (int i = 23; i >= 1; i--) send_bit(f6[i]);
    sdi = f6[0];
    sck = 1'b0;
    wait_clks(4);
    sck  = 1'b1;
    cs_n = 1'b1;
    model_bit(f6[0]);
    model_release();
    wait_clks(8);
    sck = 1'b0;
    end_test("t6");
    chk("t6_frame", {command, databyte1, databyte2}, 24'h7F0102);
    chk("t6_err_none", obs_err, 1);
    chk("total_frames", obs_q.size(), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
